// File: rtl/wrapper_register_file.sv
// -----------------------------------------------------------------------------
// wrapper_register_file
//   Integer register file for the core datapath: 2**SIZE registers of WIDTH
//   bits. Register 0 is hardwired to zero and has no storage.
//   Two asynchronous read ports and one synchronous write port.
//
// Ports
//   clk                  in   1      system clock, rising-edge active
//   reset                in   1      synchronous active-high clear of all registers
//   reg_write_WE3_i      in   1      write enable for port 3
//   write_register_A3_i  in   SIZE   write address (writes to 0 are dropped)
//   write_data_WD3_i     in   WIDTH  write data
//   read_register_A1_i   in   SIZE   read address, port 1
//   read_register_A2_i   in   SIZE   read address, port 2
//   read_data_RD1_o      out  WIDTH  read data, port 1 (combinational)
//   read_data_RD2_o      out  WIDTH  read data, port 2 (combinational)
//
// Reads never see the value being written in the same cycle; the new value
// appears only after the clock edge. Any forwarding belongs in the pipeline.
// -----------------------------------------------------------------------------
module wrapper_register_file #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write_WE3_i,
  input  logic [SIZE-1:0]  write_register_A3_i,
  input  logic [WIDTH-1:0] write_data_WD3_i,
  input  logic [SIZE-1:0]  read_register_A1_i,
  input  logic [SIZE-1:0]  read_register_A2_i,
  output logic [WIDTH-1:0] read_data_RD1_o,
  output logic [WIDTH-1:0] read_data_RD2_o
);

  localparam int NREGS = 2 ** SIZE;

  // Storage exists for registers 1..NREGS-1 only.
  logic [WIDTH-1:0] regs_q [1:NREGS-1];
  logic [WIDTH-1:0] regs_d [1:NREGS-1];

  // One-hot write decode gated by the write enable. Bit 0 is never set so a
  // write to x0 is discarded. Equality compares (rather than indexing by the
  // address) mean an unknown address decodes to no write in simulation.
  logic [NREGS-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (reg_write_WE3_i && (write_register_A3_i == SIZE'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  // Enable-register next state: hold unless selected.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) begin
        regs_d[i] = write_data_WD3_i;
      end
    end
  end

  // Reset has priority over a write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Two independent read multiplexers; address 0 falls through to zero.
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (read_register_A1_i == SIZE'(i)) begin
        rd1_d = regs_q[i];
      end
      if (read_register_A2_i == SIZE'(i)) begin
        rd2_d = regs_q[i];
      end
    end
  end

  assign read_data_RD1_o = rd1_d;
  assign read_data_RD2_o = rd2_d;

endmodule

// File: tb/tb_wrapper_register_file.sv
// -----------------------------------------------------------------------------
// tb_wrapper_register_file
//   Bench for wrapper_register_file. Each driven cycle pushes the expected
//   {RD1, RD2} pair (from a plain array model of the register contents) into a
//   queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_wrapper_register_file;

  localparam int WIDTH = 32;
  localparam int SIZE  = 5;
  localparam int NREGS = 2 ** SIZE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             we3;
  logic [SIZE-1:0]  a3;
  logic [WIDTH-1:0] wd3;
  logic [SIZE-1:0]  a1;
  logic [SIZE-1:0]  a2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  wrapper_register_file #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk                 (clk),
    .reset               (reset),
    .reg_write_WE3_i     (we3),
    .write_register_A3_i (a3),
    .write_data_WD3_i    (wd3),
    .read_register_A1_i  (a1),
    .read_register_A2_i  (a2),
    .read_data_RD1_o     (rd1),
    .read_data_RD2_o     (rd2)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] model [NREGS];

  function automatic logic [WIDTH-1:0] ref_read(input logic [SIZE-1:0] a);
    return (a == 0) ? '0 : model[a];
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*WIDTH-1:0] exp_q [$];
  logic               chk_valid = 1'b0;
  int                 n_vec  = 0;
  int                 n_fail = 0;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL underflow: monitor saw a cycle with no expectation queued");
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if (rd1 !== e[2*WIDTH-1:WIDTH]) begin
          n_fail++;
          $display("FAIL rd1 A1=%0d: got %h expected %h", a1, rd1, e[2*WIDTH-1:WIDTH]);
        end
        n_vec++;
        if (rd2 !== e[WIDTH-1:0]) begin
          n_fail++;
          $display("FAIL rd2 A2=%0d: got %h expected %h", a2, rd2, e[WIDTH-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Apply inputs for one cycle. Expected reads reflect contents before the
  // edge; the model is updated at the edge.
  task automatic drive(input logic rst, input logic we,
                       input logic [SIZE-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [SIZE-1:0] ra1, input logic [SIZE-1:0] ra2);
    reset = rst;
    we3   = we;
    a3    = wa;
    wd3   = wd;
    a1    = ra1;
    a2    = ra2;
    exp_q.push_back({ref_read(ra1), ref_read(ra2)});
    chk_valid = 1'b1;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic rd(input logic [SIZE-1:0] ra1, input logic [SIZE-1:0] ra2);
    drive(1'b0, 1'b0, '0, '0, ra1, ra2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    we3   = 1'b0;
    a3    = '0;
    wd3   = '0;
    a1    = '0;
    a2    = '0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    @(posedge clk);
    #1;

    // every address reads zero after reset
    for (int i = 0; i < NREGS; i++) rd(SIZE'(i), SIZE'(NREGS - 1 - i));

    // basic write/read
    drive(1'b0, 1'b1, 5'd2, 32'd7, 5'd0, 5'd0);
    rd(5'd2, 5'd0);
    drive(1'b0, 1'b1, 5'd4, 32'd20, 5'd0, 5'd0);
    rd(5'd4, 5'd2);

    // x0 protection
    drive(1'b0, 1'b1, 5'd0, 32'd3, 5'd0, 5'd0);
    rd(5'd0, 5'd0);

    // write disable
    drive(1'b0, 1'b0, 5'd5, 32'hDEAD, 5'd5, 5'd5);
    rd(5'd5, 5'd5);

    // top address and dual port
    drive(1'b0, 1'b1, 5'd31, 32'd6, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd19, 32'd78, 5'd0, 5'd0);
    rd(5'd31, 5'd19);
    rd(5'd31, 5'd31);

    // read during write: old value before the edge, new after
    drive(1'b0, 1'b1, 5'd2, 32'd9, 5'd2, 5'd2);
    rd(5'd2, 5'd2);

    // reset wins over a simultaneous write
    drive(1'b1, 1'b1, 5'd2, 32'h55, 5'd2, 5'd31);
    rd(5'd2, 5'd31);
    rd(5'd19, 5'd4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            SIZE'($urandom_range(0, NREGS - 1)), WIDTH'($urandom),
            SIZE'($urandom_range(0, NREGS - 1)), SIZE'($urandom_range(0, NREGS - 1)));
    end

    // drain: bounded wait for the monitor to consume everything
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    chk_valid = 1'b0;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
